dpd_coef_loader: RTL and testbench
==================================

// Module: dpd_coef_loader
// PURPOSE
//  Writer side of the intf_coef_3_5 coefficient bank (3 nonlinear orders x 5 taps = 15 complex coefs).
//  Accepts per-coefficient writes from the adaptation/host path into a shadow bank.
//  Transfers shadow -> active atomically at a datapath-safe strobe, so the DPD never sees a mixed set.
// PARAMETERS
//  N_COEF  15  number of complex coefficients (must match intf_coef_3_5)
//  W       20  coefficient word width, two's complement Q2.18
//  ADDR_W  4   write address width
// PORTS
//  clk        in   1          single clock; all logic on posedge
//  reset_n    in   1          synchronous, active-low reset
//  wr_valid   in   1          write request
//  wr_ready   out  1          shadow bank can accept a write
//  wr_addr    in   ADDR_W     coefficient index 0..N_COEF-1
//  wr_i       in   W          real part
//  wr_q       in   W          imaginary part
//  commit     in   1          pulse: shadow set complete, request swap
//  swap_en    in   1          datapath safe-point strobe (block/frame boundary)
//  pending    out  1          commit accepted, swap not yet done
//  swap_done  out  1          one-cycle pulse on the cycle active bank updates
//  addr_err   out  1          sticky: write to index >= N_COEF seen
//  coef       intf intf_coef_3_5  active bank, coef.i[k]/coef.q[k] driven by this block
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): active and shadow = identity (i[0]=20'h40000 i.e. 1.0, all other i/q=0);
//   pending=0, swap_done=0, addr_err=0, wr_ready=1. Reset mid-pending discards pending commit; shadow lost.
//  Write: accepted when wr_valid & wr_ready; shadow[wr_addr] <= {wr_i,wr_q} at that edge. No width conversion.
//  wr_addr >= N_COEF: handshake completes, data dropped, addr_err <= 1 (cleared only by reset).
//  wr_ready = ~pending (combinational from pending reg). Writes stall while swap outstanding.
//  FSM: IDLE -> (commit) -> ARMED -> (swap_en) -> IDLE.
//   IDLE: commit=1 -> pending<=1 next edge; write in same cycle as commit is accepted and included.
//   ARMED: swap_en=1 -> active <= shadow (all 15 i and q in one edge), pending<=0, swap_done<=1 for 1 cycle.
//   commit and swap_en in same IDLE cycle: commit registered only; swap waits for a later swap_en.
//   commit while ARMED: ignored (no re-arm, no error). swap_en in IDLE: no effect.
//  Latency: swap_en sampled at edge N -> coef outputs new at edge N (registered), swap_done high cycle N..N+1.
//  Shadow retains contents after swap; partial reloads permitted.
//  coef outputs always driven from active registers only; never from shadow or wr_* directly.
// CONFIGURATION
//  DPD_COEF_READBACK_EN defined: adds ports
//   rd_en in 1, rd_bank in 1 (0=active,1=shadow), rd_addr in ADDR_W, rd_i out W, rd_q out W, rd_valid out 1;
//   registered read, 1-cycle latency; rd_valid pulses cycle after rd_en; out-of-range addr returns 0;
//   rd_i/rd_q/rd_valid reset to 0. Read of shadow same cycle as write to same addr returns old value.
//  Not defined: readback ports and logic absent; all else identical.
// TESTING
//  Reset: hold reset_n=0 2 cycles -> coef.i[0]=20'h40000, all others 0, wr_ready=1, pending=0, addr_err=0.
//  Load k=0..14 i=k+1,q=-(k+1), commit, swap_en 10 cycles later -> coef unchanged until that edge, then i[k]=k+1; swap_done 1 cycle.
//  commit+swap_en same cycle -> no swap; wr_ready=0 next cycle; swap on next swap_en; wr_valid held during ARMED not accepted.
//  Write addr 15 with wr_valid -> wr_ready stays 1, shadow unchanged, addr_err=1 sticky until reset.
//  commit then reset_n=0 before swap_en -> pending=0, coef=identity, later swap_en has no effect.
//  DPD_COEF_READBACK_EN: write shadow[3]=20'h12345, read bank 1 addr 3 -> rd_i=20'h12345 one cycle later; bank 0 -> old value.

Source files
------------

// File: rtl/dpd_coef_loader_if.sv
//==============================================================================
// Interface : intf_coef_3_5
// Active DPD coefficient bank: 3 orders x 5 taps, complex, one word per part.
// Revision  : 1.0 - initial release
//==============================================================================
`default_nettype none

interface intf_coef_3_5 #(
    parameter int N_COEF = 15,
    parameter int W      = 20
);
    logic [W-1:0] i [N_COEF];
    logic [W-1:0] q [N_COEF];

    modport writer (output i, q);
    modport reader (input  i, q);
endinterface

`default_nettype wire

// File: rtl/dpd_coef_loader.sv
//==============================================================================
// Module    : dpd_coef_loader
// Shadow/active coefficient bank writer with atomic swap at a datapath strobe.
// Option    : DPD_COEF_READBACK_EN adds a registered readback port.
// Revision  : 1.0 - initial release
//==============================================================================
`default_nettype none

module dpd_coef_loader #(
    parameter int N_COEF = 15,
    parameter int W      = 20,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_i,
    input  logic [W-1:0]      wr_q,
    input  logic              commit,
    input  logic              swap_en,
    output logic              pending,
    output logic              swap_done,
    output logic              addr_err,
`ifdef DPD_COEF_READBACK_EN
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_i,
    output logic [W-1:0]      rd_q,
    output logic              rd_valid,
`endif
    intf_coef_3_5.writer      coef
);

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_ARMED  = 1'b1;
    localparam logic [W-1:0]      COEF_ONE  = W'(1) << (W - 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEF - 1);

    logic [0:0]   state_q;
    logic [0:0]   state_d;
    logic         swap_fire;
    logic         wr_fire;
    logic         wr_addr_ok;
    logic         swap_done_q;
    logic         addr_err_q;
    logic [W-1:0] sh_i_q  [N_COEF];
    logic [W-1:0] sh_q_q  [N_COEF];
    logic [W-1:0] act_i_q [N_COEF];
    logic [W-1:0] act_q_q [N_COEF];

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Commit is only seen in IDLE; a same-cycle swap_en there is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (commit)  state_d = ST_ARMED;
            ST_ARMED: if (swap_en) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pending   = (state_q == ST_ARMED);
        wr_ready  = ~pending;
        swap_fire = pending & swap_en;
    end

    assign wr_fire    = wr_valid & wr_ready;
    assign wr_addr_ok = (wr_addr <= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < N_COEF; k++) begin
                sh_i_q[k] <= (k == 0) ? COEF_ONE : '0;
                sh_q_q[k] <= '0;
            end
        end else if (wr_fire && wr_addr_ok) begin
            sh_i_q[wr_addr] <= wr_i;
            sh_q_q[wr_addr] <= wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < N_COEF; k++) begin
                act_i_q[k] <= (k == 0) ? COEF_ONE : '0;
                act_q_q[k] <= '0;
            end
        end else if (swap_fire) begin
            for (int k = 0; k < N_COEF; k++) begin
                act_i_q[k] <= sh_i_q[k];
                act_q_q[k] <= sh_q_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            swap_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            swap_done_q <= swap_fire;
            if (wr_fire && !wr_addr_ok) addr_err_q <= 1'b1;
        end
    end

    assign swap_done = swap_done_q;
    assign addr_err  = addr_err_q;

    generate
        for (genvar k = 0; k < N_COEF; k++) begin : g_coef_out
            assign coef.i[k] = act_i_q[k];
            assign coef.q[k] = act_q_q[k];
        end
    endgenerate

`ifdef DPD_COEF_READBACK_EN
    logic [W-1:0] rd_i_q;
    logic [W-1:0] rd_q_q;
    logic         rd_valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_i_q     <= '0;
            rd_q_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (rd_addr > LAST_ADDR) begin
                    rd_i_q <= '0;
                    rd_q_q <= '0;
                end else if (rd_bank) begin
                    rd_i_q <= sh_i_q[rd_addr];
                    rd_q_q <= sh_q_q[rd_addr];
                end else begin
                    rd_i_q <= act_i_q[rd_addr];
                    rd_q_q <= act_q_q[rd_addr];
                end
            end
        end
    end

    assign rd_i     = rd_i_q;
    assign rd_q     = rd_q_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dpd_coef_loader.sv
//==============================================================================
// Module    : tb_dpd_coef_loader
// Directed self-checking bench for dpd_coef_loader.
// Revision  : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dpd_coef_loader;

    localparam int N_COEF = 15;
    localparam int W      = 20;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_i;
    logic [W-1:0]      wr_q;
    logic              commit;
    logic              swap_en;
    logic              pending;
    logic              swap_done;
    logic              addr_err;
`ifdef DPD_COEF_READBACK_EN
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_i;
    logic [W-1:0]      rd_q;
    logic              rd_valid;
`endif

    intf_coef_3_5 #(.N_COEF(N_COEF), .W(W)) coef_if ();

    dpd_coef_loader #(.N_COEF(N_COEF), .W(W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_i      (wr_i),
        .wr_q      (wr_q),
        .commit    (commit),
        .swap_en   (swap_en),
        .pending   (pending),
        .swap_done (swap_done),
        .addr_err  (addr_err),
`ifdef DPD_COEF_READBACK_EN
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .rd_i      (rd_i),
        .rd_q      (rd_q),
        .rd_valid  (rd_valid),
`endif
        .coef      (coef_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_identity(input string tag);
        for (int k = 0; k < N_COEF; k++) begin
            check($sformatf("%s_i%0d", tag, k), 64'(coef_if.i[k]), (k == 0) ? 64'h40000 : 64'h0);
            check($sformatf("%s_q%0d", tag, k), 64'(coef_if.q[k]), 64'h0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_i     = '0;
        wr_q     = '0;
        commit   = 1'b0;
        swap_en  = 1'b0;
`ifdef DPD_COEF_READBACK_EN
        rd_en    = 1'b0;
        rd_bank  = 1'b0;
        rd_addr  = '0;
`endif
        @(negedge clk);

        // Reset state
        tick();
        tick();
        check_identity("rst");
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        check("rst_swap_done", 64'(swap_done), 64'd0);
        reset_n = 1'b1;
        tick();

        // Full load i=k+1, q=-(k+1)
        for (int k = 0; k < N_COEF; k++) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(k);
            wr_i     = W'(k + 1);
            wr_q     = W'(-(k + 1));
            tick();
        end
        wr_valid = 1'b0;
        check_identity("preload");
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("armed_pending", 64'(pending), 64'd1);
        check("armed_wr_ready", 64'(wr_ready), 64'd0);
        for (int c = 0; c < 9; c++) tick();
        swap_en = 1'b1;
        check_identity("preswap");
        tick();
        swap_en = 1'b0;
        check("swap_done_hi", 64'(swap_done), 64'd1);
        check("swap_pending", 64'(pending), 64'd0);
        for (int k = 0; k < N_COEF; k++) begin
            check($sformatf("load_i%0d", k), 64'(coef_if.i[k]), 64'(k + 1));
            check($sformatf("load_q%0d", k), 64'(coef_if.q[k]), 64'(20'hFFFFF - k));
        end
        tick();
        check("swap_done_lo", 64'(swap_done), 64'd0);

        // Write + commit + swap_en in one IDLE cycle: write taken, swap deferred
        wr_valid = 1'b1;
        wr_addr  = 4'd2;
        wr_i     = 20'h00100;
        wr_q     = 20'h00200;
        commit   = 1'b1;
        swap_en  = 1'b1;
        tick();
        commit   = 1'b0;
        swap_en  = 1'b0;
        wr_i     = 20'h00222;
        check("cs_pending", 64'(pending), 64'd1);
        check("cs_swap_done", 64'(swap_done), 64'd0);
        check("cs_i2_old", 64'(coef_if.i[2]), 64'd3);
        check("cs_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        tick();
        wr_valid = 1'b0;
        commit   = 1'b1;
        swap_en  = 1'b1;
        tick();
        commit   = 1'b0;
        swap_en  = 1'b0;
        check("cs_swap_done", 64'(swap_done), 64'd1);
        check("cs_i2_new", 64'(coef_if.i[2]), 64'h100);
        check("cs_q2_new", 64'(coef_if.q[2]), 64'h200);
        check("cs_no_rearm", 64'(pending), 64'd0);
        swap_en = 1'b1;
        tick();
        swap_en = 1'b0;
        check("idle_swap_noop", 64'(swap_done), 64'd0);

        // Out-of-range write
        wr_valid = 1'b1;
        wr_addr  = 4'd15;
        wr_i     = 20'h00777;
        wr_q     = 20'h00777;
        check("oor_wr_ready", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        check("oor_addr_err", 64'(addr_err), 64'd1);
        check("oor_wr_ready_after", 64'(wr_ready), 64'd1);
        commit = 1'b1;
        tick();
        commit  = 1'b0;
        swap_en = 1'b1;
        tick();
        swap_en = 1'b0;
        check("oor_i14", 64'(coef_if.i[14]), 64'd15);
        check("oor_i0", 64'(coef_if.i[0]), 64'd1);
        tick();
        tick();
        check("oor_sticky", 64'(addr_err), 64'd1);

        // Reset while armed discards the commit
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("rp_pending", 64'(pending), 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rp_pending_clr", 64'(pending), 64'd0);
        check("rp_addr_err_clr", 64'(addr_err), 64'd0);
        check_identity("rp");
        swap_en = 1'b1;
        tick();
        swap_en = 1'b0;
        check("rp_swap_noop", 64'(swap_done), 64'd0);
        check_identity("rp_after");

`ifdef DPD_COEF_READBACK_EN
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_i     = 20'h12345;
        wr_q     = 20'h00ABC;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b1;
        rd_bank  = 1'b1;
        rd_addr  = 4'd3;
        tick();
        check("rb_valid", 64'(rd_valid), 64'd1);
        check("rb_sh_i", 64'(rd_i), 64'h12345);
        check("rb_sh_q", 64'(rd_q), 64'hABC);
        rd_bank = 1'b0;
        tick();
        check("rb_act_i", 64'(rd_i), 64'h0);
        rd_bank  = 1'b1;
        wr_valid = 1'b1;
        wr_i     = 20'h54321;
        tick();
        wr_valid = 1'b0;
        check("rb_rw_old", 64'(rd_i), 64'h12345);
        tick();
        check("rb_rw_new", 64'(rd_i), 64'h54321);
        rd_addr = 4'd15;
        tick();
        check("rb_oor", 64'(rd_i), 64'h0);
        rd_en = 1'b0;
        tick();
        check("rb_valid_lo", 64'(rd_valid), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
